gtp_tx_framer: RTL and testbench

GTP_TX_FRAMER -- requirements
Module: gtp_tx_framer

---
 rtl/gtp_tx_framer.sv | 130 +++++++++++++
 tb/tb_gtp_tx_framer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gtp_tx_framer.sv
// Frames FIFO words (SOF/data/EOF tagged) into a GTP TX symbol stream with K-character
// delimiters, idle commas, frame-abort signalling and frame/drop statistics.
module gtp_tx_framer #(
  parameter logic [7:0]  IDLE_K  = 8'hBC,
  parameter logic [7:0]  SOF_K   = 8'hFB,
  parameter logic [7:0]  EOF_K   = 8'hFD,
  parameter int unsigned MAX_LEN = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        link_ready,
  input  logic [9:0]  fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [7:0]  tx_data,
  output logic        tx_charisk,
  output logic        busy,
  output logic        frame_err,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    WAIT_LINK = 3'd0,
    IDLE      = 3'd1,
    SOF       = 3'd2,
    DATA      = 3'd3,
    EOF       = 3'd4
  } state_t;

  localparam logic [1:0]  T_DATA    = 2'b00;
  localparam logic [1:0]  T_SOF     = 2'b01;
  localparam logic [1:0]  T_EOF     = 2'b10;
  localparam logic [1:0]  T_BAD     = 2'b11;
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  state_t      state;
  logic [15:0] len_cnt;
  logic [1:0]  head_type;
  logic        at_max;

  assign head_type = fifo_dout[9:8];
  assign at_max    = (len_cnt == MAX_LEN_W);
  assign busy      = (state == SOF) || (state == DATA) || (state == EOF);
  assign state_dbg = state;

  // Pop decision is combinational so the head word leaves the FIFO in the cycle it is
  // consumed; a dropped link or reset blocks every pop regardless of FIFO contents.
  always_comb begin
    fifo_rd_en = 1'b0;
    if (!rst && link_ready && !fifo_empty) begin
      case (state)
        IDLE:    fifo_rd_en = (head_type != T_SOF);
        SOF:     fifo_rd_en = 1'b1;
        DATA:    fifo_rd_en = (head_type == T_EOF) ||
                              (!at_max && ((head_type == T_DATA) || (head_type == T_BAD)));
        default: fifo_rd_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_LINK;
      tx_data    <= IDLE_K;
      tx_charisk <= 1'b1;
      frame_err  <= 1'b0;
      frame_cnt  <= 16'd0;
      drop_cnt   <= 16'd0;
      len_cnt    <= 16'd0;
    end else begin
      tx_data    <= IDLE_K;
      tx_charisk <= 1'b1;
      frame_err  <= 1'b0;
      if (!link_ready) begin
        // Losing the link while a frame is open aborts it; EOF_K never goes out.
        state     <= WAIT_LINK;
        frame_err <= busy;
      end else begin
        case (state)
          WAIT_LINK: state <= IDLE;
          IDLE: begin
            if (!fifo_empty) begin
              if (head_type == T_SOF) begin
                tx_data <= SOF_K;
                state   <= SOF;
              end else if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
              end
            end
          end
          SOF: begin
            if (!fifo_empty) begin
              tx_data    <= fifo_dout[7:0];
              tx_charisk <= 1'b0;
              len_cnt    <= 16'd1;
              state      <= DATA;
            end
          end
          DATA: begin
            if (!fifo_empty) begin
              if (head_type == T_EOF) begin
                tx_data    <= fifo_dout[7:0];
                tx_charisk <= 1'b0;
                state      <= EOF;
              end else if ((head_type == T_DATA) && !at_max) begin
                tx_data    <= fifo_dout[7:0];
                tx_charisk <= 1'b0;
                len_cnt    <= len_cnt + 16'd1;
              end else begin
                // Nested SOF, invalid word or over-length: close with EOF_K and flag it.
                tx_data   <= EOF_K;
                frame_err <= 1'b1;
                state     <= IDLE;
              end
            end
          end
          EOF: begin
            tx_data   <= EOF_K;
            frame_cnt <= frame_cnt + 16'd1;
            state     <= IDLE;
          end
          default: state <= WAIT_LINK;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gtp_tx_framer.sv
// Bench for gtp_tx_framer: a FIFO model feeds words, a stream-level reference model
// predicts the non-idle symbol sequence and counters, a monitor compares the output.
module tb_gtp_tx_framer;
  localparam int TB_MAX = 12;

  logic        clk;
  logic        rst;
  logic        link_ready;
  logic [9:0]  fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  tx_data;
  logic        tx_charisk;
  logic        busy;
  logic        frame_err;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic [2:0]  state_dbg;

  gtp_tx_framer #(.MAX_LEN(TB_MAX)) dut (
    .clk(clk), .rst(rst), .link_ready(link_ready),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .tx_data(tx_data), .tx_charisk(tx_charisk), .busy(busy), .frame_err(frame_err),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .state_dbg(state_dbg)
  );

  logic [9:0] fifo_q[$];
  logic [8:0] exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  exp_frames = 0;
  int  exp_drops  = 0;
  int  exp_errs   = 0;
  int  err_seen   = 0;
  bit  stall_en   = 0;
  bit  m_in_frame = 0;
  int  m_len      = 0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: walks the word stream applying the framing rules, with no notion of cycles.
  task automatic model_words(input logic [9:0] w[$]);
    int i = 0;
    while (i < w.size()) begin
      logic [1:0] t;
      logic [7:0] b;
      t = w[i][9:8];
      b = w[i][7:0];
      if (!m_in_frame) begin
        if (t == 2'b01) begin
          exp_q.push_back(9'h1FB);
          exp_q.push_back({1'b0, b});
          m_len = 1;
          m_in_frame = 1;
        end else begin
          exp_drops++;
        end
        i++;
      end else if (t == 2'b10) begin
        exp_q.push_back({1'b0, b});
        exp_q.push_back(9'h1FD);
        exp_frames++;
        m_in_frame = 0;
        i++;
      end else if (t == 2'b01 || m_len == TB_MAX) begin
        exp_q.push_back(9'h1FD);
        exp_errs++;
        m_in_frame = 0;
      end else if (t == 2'b11) begin
        exp_q.push_back(9'h1FD);
        exp_errs++;
        m_in_frame = 0;
        i++;
      end else begin
        exp_q.push_back({1'b0, b});
        m_len++;
        i++;
      end
    end
  endtask

  task automatic send(input logic [9:0] w[$]);
    foreach (w[k]) fifo_q.push_back(w[k]);
    model_words(w);
  endtask

  task automatic drain();
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 4000) begin
      @(posedge clk);
      n++;
    end
    check("drain_done", (n < 4000), 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_frame_cnt"}, frame_cnt, exp_frames[15:0]);
    check({tag, "_drop_cnt"}, drop_cnt, exp_drops[15:0]);
    check({tag, "_frame_err"}, err_seen, exp_errs);
  endtask

  // FIFO model: head word presented at negedge, pop applied at the following posedge.
  always begin
    bit do_pop;
    @(negedge clk);
    fifo_empty = (fifo_q.size() == 0) || (stall_en && ($urandom_range(0, 3) == 0));
    fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 10'h3FF;
    #1;
    do_pop = fifo_rd_en;
    if (!rst) check("rd_en_while_empty", {31'd0, fifo_rd_en & fifo_empty}, 0);
    @(posedge clk);
    if (do_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
  end

  // Monitor / scoreboard: every non-idle symbol must match the head of exp_q.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst) begin
      if (frame_err) err_seen++;
      if (!(tx_charisk && tx_data == 8'hBC)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_symbol", {23'd0, tx_charisk, tx_data}, 32'h1BC);
        end else begin
          e = exp_q.pop_front();
          check("tx_symbol", {23'd0, tx_charisk, tx_data}, {23'd0, e});
        end
        if (tx_charisk && tx_data == 8'hFD) check("busy_after_eof", {31'd0, busy}, 0);
        else check("busy_in_frame", {31'd0, busy}, 1);
      end
    end
  end

  initial begin
    logic [9:0] w[$];
    int n;
    fifo_dout  = 10'h3FF;
    fifo_empty = 1'b1;
    rst = 1'b1;
    link_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_data", tx_data, 8'hBC);
    check("rst_charisk", tx_charisk, 1);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    rst = 1'b0;

    // Frame queued while the link is down: nothing may be popped.
    w = '{10'h1AA, 10'h01A, 10'h01B, 10'h01C, 10'h01D, 10'h01F, 10'h02A, 10'h02B, 10'h22C};
    send(w);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("link_down_no_pop", fifo_q.size(), 9);
    link_ready = 1'b1;
    drain();
    check_counters("basic");

    // FIFO runs dry for three cycles inside a frame.
    w = '{10'h111, 10'h01A, 10'h01B};
    send(w);
    n = 0;
    while (fifo_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("underrun_wait", (n < 200), 1);
    repeat (3) @(posedge clk);
    #2;
    w = '{10'h01C, 10'h01D, 10'h21E};
    send(w);
    drain();
    check_counters("underrun");

    // Stray words before a 2-byte frame.
    w = '{10'h055, 10'h266, 10'h177, 10'h288};
    send(w);
    drain();
    check_counters("stray");

    // Length limit: 14-byte frame aborts at TB_MAX, 13-byte frame just fits.
    w.delete();
    w.push_back(10'h140);
    for (int k = 0; k < 12; k++) w.push_back(10'(8'h41 + k));
    w.push_back(10'h25F);
    send(w);
    w.delete();
    w.push_back(10'h160);
    for (int k = 0; k < 11; k++) w.push_back(10'(8'h61 + k));
    w.push_back(10'h27F);
    send(w);
    drain();
    check_counters("max_len");

    // Link drops after the 3rd frame byte: abort, leftovers dropped later.
    w = '{10'h1AA, 10'h01A, 10'h01B, 10'h01C, 10'h01D, 10'h21E};
    foreach (w[k]) fifo_q.push_back(w[k]);
    exp_q.push_back(9'h1FB);
    exp_q.push_back(9'h0AA);
    exp_q.push_back(9'h01A);
    exp_q.push_back(9'h01B);
    exp_errs++;
    exp_drops += 3;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tx_charisk == 1'b0 && tx_data == 8'h1B) && n < 200);
    check("link_drop_wait", (n < 200), 1);
    link_ready = 1'b0;
    repeat (5) @(negedge clk);
    link_ready = 1'b1;
    drain();
    check_counters("link_drop");

    // Randomized traffic with FIFO stalls, stray words and corrupted frames.
    stall_en = 1;
    w.delete();
    for (int f = 0; f < 25; f++) begin
      int len;
      int kind;
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 2))
          0:       w.push_back({2'b00, 8'($urandom)});
          1:       w.push_back({2'b10, 8'($urandom)});
          default: w.push_back({2'b11, 8'($urandom)});
        endcase
      end
      len  = $urandom_range(2, 16);
      kind = $urandom_range(0, 5);
      w.push_back({2'b01, 8'($urandom)});
      for (int k = 0; k < len - 2; k++) begin
        if (kind == 1 && k == (len - 2) / 2) w.push_back({2'b01, 8'($urandom)});
        w.push_back({2'b00, 8'($urandom)});
      end
      if (kind == 0) w.push_back({2'b11, 8'($urandom)});
      else w.push_back({2'b10, 8'($urandom)});
    end
    send(w);
    drain();
    stall_en = 0;
    check_counters("random");

    // Reset clears the statistics.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst2_frame_cnt", frame_cnt, 0);
    check("rst2_drop_cnt", drop_cnt, 0);
    check("rst2_tx_data", tx_data, 8'hBC);
    check("rst2_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
